// File: rtl/adc_capture_pkg.sv
// Shared types and default widths for the ADC acquisition path (capture, sample RAM, readout).
package adc_capture_pkg;

    localparam int DATA_W_DEF  = 10;
    localparam int ADDR_W_DEF  = 13;
    localparam int ADC_LAT_DEF = 6;
    localparam int DLY_W_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/adc_capture.sv
// ADC acquisition: after start, skips ADC latency plus a programmable delay, then writes acq_len words to RAM.
// Optional ADC_CAPTURE_AVG2_EN: each written word is the truncated mean of two consecutive samples.
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ADC_LAT = ADC_LAT_DEF,
    parameter int DLY_W   = DLY_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              start,
    input  logic              abort,
    input  logic [DLY_W-1:0]  acq_dly,
    input  logic [ADDR_W:0]   acq_len,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    // One extra bit so ADC_LAT plus the largest delay cannot overflow.
    localparam int CNT_W = DLY_W + 1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   adc_q, adc_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fin_q, fin_d;
    logic                do_wr;
    logic [DATA_W-1:0]   wr_val;
`ifdef ADC_CAPTURE_AVG2_EN
    logic                phase_q, phase_d;
    logic [DATA_W-1:0]   half_q, half_d;
    logic [DATA_W:0]     pair_sum;
`endif

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        words_d    = words_q;
        addr_d     = addr_q;
        adc_d      = adc_data;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = fin_q;
        fin_d      = 1'b0;
        do_wr      = 1'b0;
        wr_val     = adc_q;
`ifdef ADC_CAPTURE_AVG2_EN
        phase_d    = phase_q;
        half_d     = half_q;
        pair_sum   = {1'b0, half_q} + {1'b0, adc_q};
`endif

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (acq_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = CNT_W'(ADC_LAT) + CNT_W'(acq_dly);
                        words_d    = acq_len;
                        addr_d     = '0;
                        wr_addr_d  = '0;
`ifdef ADC_CAPTURE_AVG2_EN
                        phase_d    = 1'b0;
`endif
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - CNT_W'(1);
                    if (wait_cnt_q <= CNT_W'(1)) state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
`ifdef ADC_CAPTURE_AVG2_EN
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        half_d = adc_q;
                    end else begin
                        do_wr  = 1'b1;
                        wr_val = pair_sum[DATA_W:1];
                    end
`else
                    do_wr = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // The address may wrap to 0 after a full-buffer run; no write follows it.
        if (do_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = wr_val;
            addr_d    = addr_q + ADDR_W'(1);
            words_d   = words_q - (ADDR_W+1)'(1);
            if (words_q == (ADDR_W+1)'(1)) begin
                state_d = IDLE;
                fin_d   = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            words_q    <= '0;
            addr_q     <= '0;
            adc_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fin_q      <= 1'b0;
`ifdef ADC_CAPTURE_AVG2_EN
            phase_q    <= 1'b0;
            half_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            words_q    <= words_d;
            addr_q     <= addr_d;
            adc_q      <= adc_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fin_q      <= fin_d;
`ifdef ADC_CAPTURE_AVG2_EN
            phase_q    <= phase_d;
            half_q     <= half_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: ramp ADC input, expected writes queued at start, compared on wr_en.
module tb_adc_capture;
    import adc_capture_pkg::*;

    localparam int DW   = DATA_W_DEF;
    localparam int AW   = ADDR_W_DEF;
    localparam int LAT  = ADC_LAT_DEF;
    localparam int DLYW = DLY_W_DEF;
`ifdef ADC_CAPTURE_AVG2_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [DW-1:0] adc_data;
    logic [DLYW-1:0] acq_dly;
    logic [AW:0]   acq_len;
    logic          wr_en, busy, done;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    adc_capture dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .start(start), .abort(abort),
        .acq_dly(acq_dly), .acq_len(acq_len), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int edge_n;
    } exp_t;

    exp_t q[$];
    int ecount = 0;
    int n_chk = 0, n_pass = 0;
    int n_wr = 0, n_done = 0, n_busy = 0;
    int done_exp = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ecount);
    endtask

    always @(posedge clk) ecount <= ecount + 1;

    // Ramp: the value present at posedge n is n (mod 2**DW).
    initial begin
        adc_data = '0;
        forever begin
            @(negedge clk);
            adc_data = DW'(ecount + 1);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (busy) n_busy++;
        if (wr_en) begin
            n_wr++;
            if (q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                check("wr_addr", 32'(wr_addr), e.addr);
                check("wr_data", 32'(wr_data), e.data);
                check("wr_edge", ecount, e.edge_n);
            end
        end
        if (done) begin
            n_done++;
            check("done_edge", ecount, done_exp);
        end
    end

    task automatic push_exp(input int e0, input int dly, input int n);
        exp_t e;
        int s, a, b;
        for (int i = 0; i < n; i++) begin
            e.addr = i % (1 << AW);
            if (AVG) begin
                s = e0 + LAT + dly + 2 * i;
                a = s % (1 << DW);
                b = (s + 1) % (1 << DW);
                e.data = (a + b) / 2;
                e.edge_n = s + 2;
            end else begin
                s = e0 + LAT + dly + i;
                e.data = s % (1 << DW);
                e.edge_n = s + 1;
            end
            q.push_back(e);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check({tag, "_wr_data"}, 32'(wr_data), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    // Called at a negedge; start is sampled at the following posedge (E0).
    task automatic run_acq(input int dly, input int len, input bit busy_start);
        int e0, d0, b0, budget, span;
        e0 = ecount + 1;
        d0 = n_done;
        b0 = n_busy;
        span = AVG ? 2 * len : len;
        push_exp(e0, dly, len);
        done_exp = (len == 0) ? e0 : e0 + LAT + dly + span + 1;
        start = 1'b1;
        acq_dly = DLYW'(dly);
        acq_len = (AW+1)'(len);
        budget = LAT + dly + span + 20;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            start = busy_start && (ecount == e0 + 3 || ecount == e0 + LAT + dly + 1);
            if (ecount == e0) begin
                check("busy_after_start", 32'(busy), 32'(len != 0));
                acq_dly = DLYW'($urandom);
                acq_len = (AW+1)'($urandom);
            end
            if (n_done != d0) break;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("done_count", n_done - d0, 1);
        check("busy_cycles", n_busy - b0, (len == 0) ? 0 : LAT + dly + span);
        check("busy_end", 32'(busy), 0);
        check("sb_empty", q.size(), 0);
        q.delete();
    endtask

    initial begin
        int e0, w0, d0, ab;
        rst = 1'b1; start = 1'b0; abort = 1'b0; acq_dly = '0; acq_len = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        while (ecount < 99) @(negedge clk);
        run_acq(0, 8, 1'b0);
        run_acq(20, 4, 1'b0);
        run_acq(0, 0, 1'b0);
        run_acq(10, 4, 1'b1);

        // start and abort together in IDLE: nothing starts
        w0 = n_wr; d0 = n_done;
        start = 1'b1; abort = 1'b1; acq_dly = '0; acq_len = 4;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (LAT + 12) @(negedge clk);
        check("startabort_busy", 32'(busy), 0);
        check("startabort_writes", n_wr - w0, 0);
        check("startabort_done", n_done - d0, 0);

        // abort during CAPTURE after three writes
        w0 = n_wr; d0 = n_done;
        e0 = ecount + 1;
        push_exp(e0, 0, 3);
        start = 1'b1; acq_dly = '0; acq_len = 16;
        ab = AVG ? e0 + LAT + 6 : e0 + LAT + 3;
        @(negedge clk);
        start = 1'b0;
        while (ecount < ab) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_wr_en", 32'(wr_en), 0);
        repeat (10) @(negedge clk);
        check("abort_writes", n_wr - w0, 3);
        check("abort_no_done", n_done - d0, 0);
        check("abort_sb_empty", q.size(), 0);
        q.delete();
        run_acq(0, 4, 1'b0);

        // reset during WAIT
        w0 = n_wr;
        start = 1'b1; acq_dly = 20; acq_len = 4;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_wait");
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_wait_writes", n_wr - w0, 0);

        // reset during CAPTURE
        w0 = n_wr; d0 = n_done;
        e0 = ecount + 1;
        push_exp(e0, 0, 8);
        start = 1'b1; acq_dly = '0; acq_len = 8;
        @(negedge clk);
        start = 1'b0;
        while (ecount < e0 + LAT + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_capture");
        q.delete();
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_capture_writes", n_wr - w0, AVG ? 1 : 2);
        check("rst_capture_no_done", n_done - d0, 0);

        run_acq(5, 3, 1'b0);
        run_acq(0, 1 << AW, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
